axil_mmio_regfile: RTL and testbench
====================================

Name: axil_mmio_regfile

Overview:
- Parametrised AXI4-Lite slave register file; next generation of the single-register MMIO controller.
- Sits between the SoC AXI-Lite interconnect and peripheral control/status logic.
- Adds the following over the single-register version:
  - NUM_REGS-deep register array.
  - Byte strobes.
  - Read-only/status registers driven by hardware.
  - DECERR/SLVERR responses.
  - Fair read/write arbitration.

Parameters:
- DATA_W, 32: AXI data width and register width; must be 32 or 64.
- ADDR_W, 12: AXI address width.
- NUM_REGS, 16: number of registers; register i sits at byte offset i*(DATA_W/8).
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only (value comes from hw_status).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_W  write data
- s_wstrb  in  DATA_W/8  byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response (resp_t)
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_W  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_W  read data
- s_rresp  out  2  read response (resp_t)
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- reg_out  out  NUM_REGS*DATA_W  flattened contents of the register array
- hw_status  in  NUM_REGS*DATA_W  values returned for RO registers (other slices ignored)

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - All ready/valid outputs 0.
  - s_bresp, s_rresp = AXI_RESP_OKAY.
  - s_rdata = 0.
  - All writable registers 0.
  - State IDLE.
  - Arbitration priority pointer = write.
- FSM states: IDLE, WRITE, WRITE_RESP, READ, READ_RESP. These extend axi_mmio_state_t semantics; the enum lives in const_pkg.
- IDLE transitions:
  - Write pending (s_awvalid && s_wvalid) and no read pending: go to WRITE.
  - Read pending (s_arvalid) and no write pending: go to READ.
  - Both pending: the priority pointer picks one. The pointer then flips to the other kind, so back-to-back contention alternates W, R, W, R.
  - An AW or W arriving alone is not accepted; the slave waits for both.
- WRITE:
  - s_awready = s_wready = 1 for exactly one cycle; address and data are captured.
  - Decode index = awaddr[ADDR_W-1:log2(DATA_W/8)].
  - Index < NUM_REGS and not RO: each byte with wstrb=1 is updated. Response OKAY.
  - Index < NUM_REGS and RO: no update. Response SLVERR.
  - Index >= NUM_REGS: no update. Response DECERR.
  - Misaligned low address bits are ignored.
  - Next state: WRITE_RESP.
- WRITE_RESP:
  - s_bvalid=1, s_bresp held stable until s_bready.
  - On handshake: s_bvalid clears the next cycle; return to IDLE.
- READ:
  - s_arready=1 for one cycle; address captured.
  - s_rdata is loaded from:
    - the register (RW), or
    - the hw_status slice (RO), or
    - 0 with DECERR (out of range).
  - Next state: READ_RESP.
- READ_RESP:
  - s_rvalid=1, s_rdata/s_rresp held stable until s_rready; then return to IDLE.
- Latency:
  - Accept to B/R valid = 1 cycle after the ready pulse.
  - Minimum transaction = 3 cycles.
  - No outstanding transactions (single-issue).
- reg_out reflects a write on the cycle after the WRITE state.
- Reset mid-transaction:
  - Abandons the transaction; no response is issued.
  - Partial writes cannot occur, since the update happens atomically in WRITE.
- s_wstrb = 0: legal. No register change; response is still OKAY (for an in-range RW target).

Optional Feature:
- Macro AXIL_MMIO_WR_PULSE_EN.
- Defined:
  - Adds output port wr_pulse [NUM_REGS-1:0].
  - Bit i pulses high for one cycle, the cycle after a successful OKAY write to register i, including wstrb=0.
- Undefined: the port and its logic are absent.

Test Plan:
- Write 0xDEADBEEF, wstrb=4'hF, to addr 0x008 → bresp OKAY; reg_out[2] = 0xDEADBEEF; read 0x008 returns the same value, rresp OKAY.
- Register 3 = 0xDEADBEEF; write 0x000000AA with wstrb=4'b0001 to 0x00C → register 3 = 0xDEADBEAA.
- RO_MASK bit 1 set, hw_status[1] = 0x12345678:
  - Write to 0x004 → SLVERR, no change.
  - Read 0x004 → 0x12345678, OKAY.
- Read 0x040 with NUM_REGS=16 → rresp DECERR, rdata 0.
  - Write to 0x040 → bresp DECERR, no register changes.
- AW/W and AR held valid simultaneously for 4 transactions from reset → service order W, R, W, R.
- Assert rst during WRITE_RESP with s_bready=0 → all outputs at reset values immediately; registers cleared to 0.
  - With AXIL_MMIO_WR_PULSE_EN defined, an earlier OKAY write to 0x000 shows wr_pulse[0] high for exactly 1 cycle.

Source files
------------

// File: rtl/axil_mmio_regfile.sv
// AXI4-Lite slave register file with byte strobes, hardware-driven read-only
// registers, SLVERR/DECERR responses and alternating read/write arbitration.
// Optional feature macro: AXIL_MMIO_WR_PULSE_EN (adds per-register wr_pulse output).

package const_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_WRITE_RESP = 3'd2,
        ST_READ       = 3'd3,
        ST_READ_RESP  = 3'd4
    } axil_mmio_state_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } resp_t;

endpackage

module axil_mmio_regfile
    import const_pkg::*;
#(
    parameter int                     DATA_W   = 32,
    parameter int                     ADDR_W   = 12,
    parameter int                     NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0]    RO_MASK  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            s_awaddr,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [DATA_W-1:0]            s_wdata,
    input  logic [DATA_W/8-1:0]          s_wstrb,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [ADDR_W-1:0]            s_araddr,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status
`ifdef AXIL_MMIO_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]          wr_pulse
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;

    axil_mmio_state_t                 state_q;
    logic                             prio_wr_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
    logic                             awready_q;
    logic                             wready_q;
    logic                             bvalid_q;
    resp_t                            bresp_q;
    logic                             arready_q;
    logic                             rvalid_q;
    resp_t                            rresp_q;
    logic [DATA_W-1:0]                rdata_q;
`ifdef AXIL_MMIO_WR_PULSE_EN
    logic [NUM_REGS-1:0]              wr_pulse_q;
`endif

    logic [IDX_W-1:0]                 aw_idx_s;
    logic [IDX_W-1:0]                 ar_idx_s;
    logic [NUM_REGS-1:0]              wsel_s;
    logic [NUM_REGS-1:0]              rsel_s;
    logic                             wr_req_s;
    logic                             rd_req_s;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_d;
    resp_t                            bresp_d;
    logic [NUM_REGS-1:0]              pulse_d;
    logic [DATA_W-1:0]                rdata_d;
    resp_t                            rresp_d;
    logic                             unused_s;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Sub-word address bits and hw_status slices of writable registers carry no meaning here.
    assign unused_s = ^{s_awaddr[OFF_W-1:0], s_araddr[OFF_W-1:0], hw_status};

    assign wr_req_s = s_awvalid && s_wvalid;
    assign rd_req_s = s_arvalid;
    assign aw_idx_s = s_awaddr[ADDR_W-1:OFF_W];
    assign ar_idx_s = s_araddr[ADDR_W-1:OFF_W];

    // Write decode: target select, response code and byte-merged next register image.
    always_comb begin
        wsel_s  = '0;
        regs_d  = regs_q;
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wsel_s[i] = (aw_idx_s == IDX_W'(i));
        end
        if (wsel_s == '0) begin
            bresp_d = AXI_RESP_DECERR;
        end else if ((wsel_s & RO_MASK) != '0) begin
            bresp_d = AXI_RESP_SLVERR;
        end else begin
            bresp_d = AXI_RESP_OKAY;
            pulse_d = wsel_s;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wsel_s[i] && !RO_MASK[i]) begin
                regs_d[i] = merge_bytes(regs_q[i], s_wdata, s_wstrb);
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Read decode: RO registers reflect live hw_status, out-of-range reads return zero.
    always_comb begin
        rsel_s  = '0;
        rdata_d = {DATA_W{1'b0}};
        rresp_d = AXI_RESP_DECERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            rsel_s[i] = (ar_idx_s == IDX_W'(i));
            if (rsel_s[i]) begin
                rdata_d = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : regs_q[i];
                rresp_d = AXI_RESP_OKAY;
            end else begin
                rdata_d = rdata_d;
                rresp_d = rresp_d;
            end
        end
    end

    // Transaction FSM with arbitration pointer, register array and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prio_wr_q  <= 1'b1;
            regs_q     <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= AXI_RESP_OKAY;
            rdata_q    <= {DATA_W{1'b0}};
`ifdef AXIL_MMIO_WR_PULSE_EN
            wr_pulse_q <= '0;
`endif
        end else begin
`ifdef AXIL_MMIO_WR_PULSE_EN
            wr_pulse_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    // On contention the pointer hands the next turn to the other kind.
                    if (wr_req_s && (!rd_req_s || prio_wr_q)) begin
                        state_q   <= ST_WRITE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        if (rd_req_s) begin
                            prio_wr_q <= 1'b0;
                        end
                    end else if (rd_req_s) begin
                        state_q   <= ST_READ;
                        arready_q <= 1'b1;
                        if (wr_req_s) begin
                            prio_wr_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    regs_q    <= regs_d;
                    bresp_q   <= bresp_d;
                    bvalid_q  <= 1'b1;
                    state_q   <= ST_WRITE_RESP;
`ifdef AXIL_MMIO_WR_PULSE_EN
                    wr_pulse_q <= pulse_d;
`endif
                end
                ST_WRITE_RESP: begin
                    if (s_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q  <= ST_WRITE_RESP;
                    end
                end
                ST_READ: begin
                    arready_q <= 1'b0;
                    rdata_q   <= rdata_d;
                    rresp_q   <= rresp_d;
                    rvalid_q  <= 1'b1;
                    state_q   <= ST_READ_RESP;
                end
                ST_READ_RESP: begin
                    if (s_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q  <= ST_READ_RESP;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign reg_out   = regs_q;
`ifdef AXIL_MMIO_WR_PULSE_EN
    assign wr_pulse  = wr_pulse_q;
`endif

endmodule

// File: tb/tb_axil_mmio_regfile.sv
// Self-checking bench for axil_mmio_regfile: directed cases plus randomized
// traffic scored against an array-based register model.

module tb_axil_mmio_regfile;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0202;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   s_awaddr = '0;
    logic            s_awvalid = 1'b0;
    logic            s_awready;
    logic [DW-1:0]   s_wdata = '0;
    logic [DW/8-1:0] s_wstrb = '0;
    logic            s_wvalid = 1'b0;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready = 1'b0;
    logic [AW-1:0]   s_araddr = '0;
    logic            s_arvalid = 1'b0;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready = 1'b0;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] hw_status = '0;
`ifdef AXIL_MMIO_WR_PULSE_EN
    logic [NR-1:0]   wr_pulse;
`endif

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] m_regs [NR];

    axil_mmio_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_out(reg_out), .hw_status(hw_status)
`ifdef AXIL_MMIO_WR_PULSE_EN
        , .wr_pulse(wr_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
    endtask

    // Reference: index = byte address / 4; out of range -> DECERR(3), RO -> SLVERR(2).
    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [3:0] s, output logic [1:0] resp, output int idx);
        idx = int'(a) / 4;
        if (idx >= NR) resp = 2'd3;
        else if (RO[idx]) resp = 2'd2;
        else begin
            resp = 2'd0;
            for (int b = 0; b < 4; b++)
                if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NR) begin d = '0; resp = 2'd3; end
        else if (RO[idx]) begin d = hw_status[idx*DW +: DW]; resp = 2'd0; end
        else begin d = m_regs[idx]; resp = 2'd0; end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s:reg%0d", tag, i), {32'd0, reg_out[i*DW +: DW]}, {32'd0, m_regs[i]});
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input string tag, output logic [1:0] resp_o);
        logic [1:0] exp_resp;
        logic [NR-1:0] exp_pulse;
        int idx;
        int n;
        model_write(a, d, s, exp_resp, idx);
        exp_pulse = '0;
        if (exp_resp == 2'd0) exp_pulse[idx] = 1'b1;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        n = 0;
        while (!(s_awready && s_wready) && n < 16) begin @(negedge clk); n++; end
        chk({tag, ":aw_w_accept"}, {63'd0, s_awready & s_wready}, 64'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk({tag, ":bvalid_latency"}, {63'd0, s_bvalid}, 64'd1);
        chk({tag, ":awready_one_cycle"}, {63'd0, s_awready}, 64'd0);
        chk({tag, ":bresp"}, {62'd0, s_bresp}, {62'd0, exp_resp});
        check_regs(tag);
`ifdef AXIL_MMIO_WR_PULSE_EN
        chk({tag, ":wr_pulse"}, {48'd0, wr_pulse}, {48'd0, exp_pulse});
`endif
        resp_o = s_bresp;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        chk({tag, ":bvalid_clear"}, {63'd0, s_bvalid}, 64'd0);
`ifdef AXIL_MMIO_WR_PULSE_EN
        chk({tag, ":wr_pulse_end"}, {48'd0, wr_pulse}, 64'd0);
`endif
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string tag, output logic [DW-1:0] data_o);
        logic [DW-1:0] exp_d;
        logic [1:0] exp_resp;
        int n;
        model_read(a, exp_d, exp_resp);
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
        n = 0;
        while (!s_arready && n < 16) begin @(negedge clk); n++; end
        chk({tag, ":ar_accept"}, {63'd0, s_arready}, 64'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        chk({tag, ":rvalid_latency"}, {63'd0, s_rvalid}, 64'd1);
        chk({tag, ":rdata"}, {32'd0, s_rdata}, {32'd0, exp_d});
        chk({tag, ":rresp"}, {62'd0, s_rresp}, {62'd0, exp_resp});
        @(posedge clk); #1;
        chk({tag, ":rdata_hold"}, {31'd0, s_rvalid, s_rdata}, {31'd0, 1'b1, exp_d});
        data_o = s_rdata;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        chk({tag, ":rvalid_clear"}, {63'd0, s_rvalid}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":ready_valid"}, {59'd0, s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 64'd0);
        chk({tag, ":resp"}, {60'd0, s_bresp, s_rresp}, 64'd0);
        chk({tag, ":rdata"}, {32'd0, s_rdata}, 64'd0);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s:reg%0d", tag, i), {32'd0, reg_out[i*DW +: DW]}, 64'd0);
    endtask

    initial begin
        logic [1:0]    r;
        logic [DW-1:0] rd;
        logic [1:0]    dummy_r;
        int            dummy_i;
        bit            order [4];
        int            got;
        int            cyc;

        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic full-word write/read
        do_write(12'h008, 32'hDEADBEEF, 4'hF, "wr_full", r);
        chk("wr_full:okay", {62'd0, r}, 64'd0);
        chk("wr_full:reg2", {32'd0, reg_out[2*DW +: DW]}, {32'd0, 32'hDEADBEEF});
        do_read(12'h008, "rd_full", rd);
        chk("rd_full:value", {32'd0, rd}, {32'd0, 32'hDEADBEEF});

        // Byte strobe merge
        do_write(12'h00C, 32'hDEADBEEF, 4'hF, "wr_r3", r);
        do_write(12'h00C, 32'h000000AA, 4'b0001, "wr_strb", r);
        chk("wr_strb:reg3", {32'd0, reg_out[3*DW +: DW]}, {32'd0, 32'hDEADBEAA});

        // Read-only register
        hw_status[1*DW +: DW] = 32'h12345678;
        do_write(12'h004, 32'hFFFFFFFF, 4'hF, "wr_ro", r);
        chk("wr_ro:slverr", {62'd0, r}, 64'd2);
        do_read(12'h004, "rd_ro", rd);
        chk("rd_ro:value", {32'd0, rd}, {32'd0, 32'h12345678});

        // Out of range
        do_read(12'h040, "rd_oor", rd);
        do_write(12'h040, 32'h5A5A5A5A, 4'hF, "wr_oor", r);
        chk("wr_oor:decerr", {62'd0, r}, 64'd3);

        // Zero strobe and misaligned address
        do_write(12'h010, 32'h11111111, 4'h0, "wr_strb0", r);
        chk("wr_strb0:okay", {62'd0, r}, 64'd0);
        do_write(12'h00B, 32'hCAFEF00D, 4'hF, "wr_misalign", r);
        chk("wr_misalign:reg2", {32'd0, reg_out[2*DW +: DW]}, {32'd0, 32'hCAFEF00D});

        // AW without W must wait
        @(negedge clk);
        s_awaddr = 12'h000; s_awvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("aw_alone:no_accept", {63'd0, s_awready}, 64'd0);
        end
        s_awvalid = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            if (k % 10 == 0) begin
                hw_status[1*DW +: DW] = $urandom;
                hw_status[9*DW +: DW] = $urandom;
            end
            if ($urandom_range(0, 1) == 1)
                do_write(12'($urandom_range(0, 16'h4F)), $urandom, 4'($urandom_range(0, 15)),
                         $sformatf("rnd_wr%0d", k), r);
            else
                do_read(12'($urandom_range(0, 16'h4F)), $sformatf("rnd_rd%0d", k), rd);
        end

        // Contention from reset: W, R, W, R
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        model_clear();
        s_awaddr = 12'h010; s_wdata = 32'hC0FFEE00; s_wstrb = 4'hF; s_araddr = 12'h010;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (s_awready && s_wready) begin order[got] = 1'b1; got++; end
            else if (s_arready) begin order[got] = 1'b0; got++; end
            @(posedge clk); #1;
            if (got == 4) begin s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; end
        end
        chk("arb:grants", got, 64'd4);
        chk("arb:order0_w", {63'd0, order[0]}, 64'd1);
        chk("arb:order1_r", {63'd0, order[1]}, 64'd0);
        chk("arb:order2_w", {63'd0, order[2]}, 64'd1);
        chk("arb:order3_r", {63'd0, order[3]}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        s_bready = 1'b0; s_rready = 1'b0;
        model_write(12'h010, 32'hC0FFEE00, 4'hF, dummy_r, dummy_i);
        check_regs("arb");

        // Reset while a write response is pending
        do_write(12'h000, 32'h55AA55AA, 4'hF, "pre_rst_wr", r);
        @(negedge clk);
        s_awaddr = 12'h008; s_wdata = 32'h01020304; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        cyc = 0;
        while (!(s_awready && s_wready) && cyc < 16) begin @(negedge clk); cyc++; end
        chk("rst_mid:accept", {63'd0, s_awready & s_wready}, 64'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_mid:bvalid_hold", {61'd0, s_bvalid, s_bresp}, {61'd0, 1'b1, 2'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid:no_response", {63'd0, s_bvalid}, 64'd0);
        do_read(12'h000, "post_rst_rd", rd);
        chk("post_rst_rd:zero", {32'd0, rd}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
